// File: rtl/alu_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU arbiter slice.
//   alu_op_e    : the sixteen 4-bit opcodes understood by the shared ALU
//   arb_state_e : arbiter sequencing states
//   MUL_ITER    : number of shift-add iterations a multiply takes
// ----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [3:0] {
      OP_RED_OR  = 4'h0,
      OP_RED_AND = 4'h1,
      OP_RED_XOR = 4'h2,
      OP_OR      = 4'h3,
      OP_AND     = 4'h4,
      OP_XOR     = 4'h5,
      OP_GT      = 4'h6,
      OP_LT      = 4'h7,
      OP_NE      = 4'h8,
      OP_EQ      = 4'h9,
      OP_ADD     = 4'hA,
      OP_SUB     = 4'hB,
      OP_MUL     = 4'hC,
      OP_SHR     = 4'hD,
      OP_SHL     = 4'hE,
      OP_NOT     = 4'hF
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_RESP = 2'd3
   } arb_state_e;

   localparam int MUL_ITER = 4;

endpackage

// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if
// Request/response bundle between the requesting units and the ALU arbiter.
//   req_valid/req_ready : per-requester handshake (N_REQ bits each)
//   req_op/req_a/req_b  : 4-bit slices, slice i belongs to requester i
//   rsp_valid/rsp_ready : single shared response handshake
//   rsp_id              : index of the requester that owns the response
//   rsp_lo/rsp_hi       : result nibbles
// master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface alu_arbiter_if #(
   parameter int N_REQ = 2,
   parameter int ID_W  = $clog2(N_REQ)
);

   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [4*N_REQ-1:0] req_op;
   logic [4*N_REQ-1:0] req_a;
   logic [4*N_REQ-1:0] req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [ID_W-1:0]    rsp_id;
   logic [3:0]         rsp_lo;
   logic [3:0]         rsp_hi;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_lo, rsp_hi
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_lo, rsp_hi
   );

endinterface

// File: rtl/alu_arbiter_core.sv
// ----------------------------------------------------------------------------
// alu_core
// Purely combinational 4-bit ALU. Produces an 8-bit result {hi,lo} for every
// opcode except multiply, which is sequenced by the arbiter itself.
//   i_op     : opcode
//   i_a, i_b : 4-bit operands
//   o_result : {hi,lo}; bits an opcode does not use are zero
// ----------------------------------------------------------------------------
module alu_core
   import alu_pkg::*;
(
   input  alu_op_e    i_op,
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [7:0] o_result
);

   // Shifts work on the zero-extended byte so that bits shifted left past
   // the high nibble fall off and a shift amount of 8 or more yields zero.
   // Multiply is not computed here and reads as zero.
   always_comb begin
      o_result = '0;
      case (i_op)
         OP_RED_OR:  o_result[0]   = |i_a;
         OP_RED_AND: o_result[0]   = &i_a;
         OP_RED_XOR: o_result[0]   = ^i_a;
         OP_OR:      o_result[3:0] = i_a | i_b;
         OP_AND:     o_result[3:0] = i_a & i_b;
         OP_XOR:     o_result[3:0] = i_a ^ i_b;
         OP_GT:      o_result[0]   = (i_a > i_b);
         OP_LT:      o_result[0]   = (i_a < i_b);
         OP_NE:      o_result[0]   = (i_a != i_b);
         OP_EQ:      o_result[0]   = (i_a == i_b);
         OP_ADD:     o_result[4:0] = {1'b0, i_a} + {1'b0, i_b};
         OP_SUB:     o_result[3:0] = i_a - i_b;
         OP_MUL:     o_result      = '0;
         OP_SHR:     o_result      = {4'b0000, i_a} >> i_b;
         OP_SHL:     o_result      = {4'b0000, i_a} << i_b;
         OP_NOT:     o_result[3:0] = ~i_a;
         default:    o_result      = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
// Shares one 4-bit ALU between N_REQ requesters. A round-robin search picks a
// requester in IDLE, its opcode/operands are latched, the op runs on alu_core
// (one cycle) or on the internal shift-add multiplier (four cycles), and the
// result is presented on the shared response channel until consumed.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : alu_arbiter_if.slave (request and response handshakes)
//   grant_cnt : per-requester saturating accept counters, 16 bits each,
//               present only when ALU_ARB_STATS_EN is defined
// Parameters: N_REQ (2..8), ID_W (requester index width).
// ----------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   alu_arbiter_if.slave       bus
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [16*N_REQ-1:0] grant_cnt
`endif
);

   arb_state_e       r_state;
   logic [ID_W-1:0]  r_lastGrant;
   alu_op_e          r_op;
   logic [3:0]       r_a;
   logic [3:0]       r_b;
   logic [7:0]       r_acc;
   logic [1:0]       r_mulCnt;
   logic             r_rspValid;
   logic [ID_W-1:0]  r_rspId;
   logic [3:0]       r_rspLo;
   logic [3:0]       r_rspHi;

   logic [3:0]       w_opArr [N_REQ];
   logic [3:0]       w_aArr  [N_REQ];
   logic [3:0]       w_bArr  [N_REQ];
   logic [N_REQ-1:0] w_grant;
   logic             w_grantAny;
   logic [ID_W-1:0]  w_grantId;
   logic             w_accept;
   logic [7:0]       w_coreResult;
   logic [7:0]       w_mulAddend;
   logic [7:0]       w_mulSum;

   // Unpack the flat request buses into per-requester nibbles so the
   // arbiter can select by index without variable part-selects.
   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_opArr[g] = bus.req_op[4*g +: 4];
      assign w_aArr[g]  = bus.req_a[4*g +: 4];
      assign w_bArr[g]  = bus.req_b[4*g +: 4];
   end

   // Round-robin search: start one past the last winner and wrap around,
   // taking the first valid requester. Because the offset runs 1..N_REQ the
   // last winner is considered last, so a lone requester still wins.
   always_comb begin
      int idxInt;
      logic [ID_W-1:0] idx;
      idxInt     = 0;
      idx        = '0;
      w_grant    = '0;
      w_grantAny = 1'b0;
      w_grantId  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idxInt = (int'(r_lastGrant) + k) % N_REQ;
         idx    = ID_W'(idxInt);
         if (!w_grantAny && bus.req_valid[idx]) begin
            w_grantAny   = 1'b1;
            w_grant[idx] = 1'b1;
            w_grantId    = idx;
         end
      end
   end

   // The grant is only offered while idle, and is forced low while reset is
   // asserted so that req_ready drops with reset rather than at the next edge.
   assign w_accept      = (r_state == ST_IDLE) && w_grantAny;
   assign bus.req_ready = ((r_state == ST_IDLE) && !rst) ? w_grant : '0;

   // One multiply iteration: add A shifted by the iteration index whenever
   // the matching bit of B is set.
   assign w_mulAddend = r_b[r_mulCnt] ? ({4'b0000, r_a} << r_mulCnt) : 8'd0;
   assign w_mulSum    = r_acc + w_mulAddend;

   alu_core u_core (
      .i_op     (r_op),
      .i_a      (r_a),
      .i_b      (r_b),
      .o_result (w_coreResult)
   );

   // Main sequencer. IDLE latches the winning request; EXEC registers the
   // combinational ALU result; MUL runs MUL_ITER shift-add steps and
   // registers the product on the last one; RESP holds the response until
   // the consumer takes it. Reset abandons any op in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_lastGrant <= ID_W'(N_REQ - 1);
         r_op        <= OP_RED_OR;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_mulCnt    <= '0;
         r_rspValid  <= 1'b0;
         r_rspId     <= '0;
         r_rspLo     <= '0;
         r_rspHi     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op        <= alu_op_e'(w_opArr[w_grantId]);
                  r_a         <= w_aArr[w_grantId];
                  r_b         <= w_bArr[w_grantId];
                  r_rspId     <= w_grantId;
                  r_lastGrant <= w_grantId;
                  r_acc       <= '0;
                  r_mulCnt    <= '0;
                  r_state     <= (w_opArr[w_grantId] == OP_MUL) ? ST_MUL : ST_EXEC;
               end
            end
            ST_EXEC: begin
               {r_rspHi, r_rspLo} <= w_coreResult;
               r_rspValid         <= 1'b1;
               r_state            <= ST_RESP;
            end
            ST_MUL: begin
               if (r_mulCnt == 2'(MUL_ITER - 1)) begin
                  {r_rspHi, r_rspLo} <= w_mulSum;
                  r_rspValid         <= 1'b1;
                  r_state            <= ST_RESP;
               end else begin
                  r_acc    <= w_mulSum;
                  r_mulCnt <= r_mulCnt + 2'd1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  r_rspValid <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.rsp_valid = r_rspValid;
   assign bus.rsp_id    = r_rspId;
   assign bus.rsp_lo    = r_rspLo;
   assign bus.rsp_hi    = r_rspHi;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] r_grantCnt [N_REQ];

   // Count accept handshakes per requester, sticking at all-ones instead of
   // wrapping so a long-running count never looks small.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            r_grantCnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (w_accept && w_grant[i] && (r_grantCnt[i] != 16'hFFFF)) begin
               r_grantCnt[i] <= r_grantCnt[i] + 16'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < N_REQ; g++) begin : g_stats
      assign grant_cnt[16*g +: 16] = r_grantCnt[g];
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter with two requesters: a table of single
// operations, hand-written backpressure / reset / round-robin sequences, and
// a randomized run compared against a behavioural model.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int N = 2;

   typedef struct {
      logic [3:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] res;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   gotId, gotRes, gotLat;

   always #5 clk = ~clk;

   // Cycle counter used to measure latencies.
   always @(posedge clk) cyc <= cyc + 1;

   alu_arbiter_if #(.N_REQ(N)) bus ();

`ifdef ALU_ARB_STATS_EN
   logic [16*N-1:0] grantCnt;
   int issued [N];

   // Independent tally of observed accept handshakes for the stats counters.
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) issued[i] = 0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) issued[i] = issued[i] + 1;
         end
      end
   end
`endif

   alu_arbiter #(.N_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus)
`ifdef ALU_ARB_STATS_EN
      ,
      .grant_cnt (grantCnt)
`endif
   );

   // Behavioural ALU written from the opcode definitions with plain integers.
   function automatic int refAlu(input int op, input int a, input int b);
      case (op)
         0:  return (a != 0) ? 1 : 0;
         1:  return (a == 15) ? 1 : 0;
         2:  return $countones(a) % 2;
         3:  return a | b;
         4:  return a & b;
         5:  return a ^ b;
         6:  return (a > b) ? 1 : 0;
         7:  return (a < b) ? 1 : 0;
         8:  return (a != b) ? 1 : 0;
         9:  return (a == b) ? 1 : 0;
         10: return a + b;
         11: return (a - b + 16) % 16;
         12: return a * b;
         13: return a / (1 << b);
         14: return (b >= 8) ? 0 : (a * (1 << b)) % 256;
         default: return 15 - a;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: wait expired, got no event, expected one", name);
   endtask

   task automatic doReset();
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Issue one op from requester rq alone, measure latency, hold rsp_ready low
   // for 'stall' cycles checking the response stays put, then consume it.
   task automatic applyStimulus(input int rq, input logic [3:0] op, input logic [3:0] a,
                                input logic [3:0] b, input logic [7:0] expRes, input int stall);
      int  tAcc;
      bit  ok;
      @(posedge clk);
      #1;
      bus.req_valid[rq]      = 1'b1;
      bus.req_op[4*rq +: 4]  = op;
      bus.req_a[4*rq +: 4]   = a;
      bus.req_b[4*rq +: 4]   = b;
      ok = 1'b0;
      for (int w = 0; w < 30; w++) begin
         @(negedge clk);
         if (bus.req_ready[rq]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         timeoutFail("grant_wait");
         bus.req_valid[rq] = 1'b0;
         return;
      end
      tAcc = cyc;
      checkOutput("grant_onehot", 32'(bus.req_ready), 32'(1 << rq));
      @(posedge clk);
      #1;
      bus.req_valid[rq] = 1'b0;
      ok = 1'b0;
      for (int w = 0; w < 30; w++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         timeoutFail("rsp_wait");
         return;
      end
      gotLat = cyc - tAcc;
      gotId  = int'(bus.rsp_id);
      gotRes = int'({bus.rsp_hi, bus.rsp_lo});
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         checkOutput("stall_valid", 32'(bus.rsp_valid), 32'd1);
         checkOutput("stall_data", 32'({bus.rsp_hi, bus.rsp_lo}), 32'(expRes));
         checkOutput("stall_req_ready", 32'(bus.req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      checkOutput("rsp_dropped", 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t vecs[$];
      int   order[$];
      int   remaining [N];
      int   mLast, mRespCyc, mExpId, mExpRes, g, j;
      bit   mBusy, expRsp, ok;
      logic [N-1:0] expReady;
      logic [3:0]   op;

      vecs.push_back('{4'hA, 4'h9, 4'h8, 8'h11});
      vecs.push_back('{4'hC, 4'hF, 4'hF, 8'hE1});
      vecs.push_back('{4'h3, 4'h5, 4'hA, 8'h0F});
      vecs.push_back('{4'hE, 4'hF, 4'h8, 8'h00});
      vecs.push_back('{4'hD, 4'h8, 4'h3, 8'h01});
      vecs.push_back('{4'h6, 4'h3, 4'h3, 8'h00});
      vecs.push_back('{4'h0, 4'h0, 4'h5, 8'h00});
      vecs.push_back('{4'h1, 4'hF, 4'h0, 8'h01});
      vecs.push_back('{4'h2, 4'h7, 4'h0, 8'h01});
      vecs.push_back('{4'h4, 4'hC, 4'hA, 8'h08});
      vecs.push_back('{4'h5, 4'hC, 4'hA, 8'h06});
      vecs.push_back('{4'h7, 4'h2, 4'h9, 8'h01});
      vecs.push_back('{4'h8, 4'h4, 4'h4, 8'h00});
      vecs.push_back('{4'h9, 4'h4, 4'h4, 8'h01});
      vecs.push_back('{4'hB, 4'h3, 4'h5, 8'h0E});
      vecs.push_back('{4'hF, 4'h5, 4'h0, 8'h0A});
      vecs.push_back('{4'hE, 4'h3, 4'h2, 8'h0C});
      vecs.push_back('{4'hD, 4'hF, 4'h1, 8'h07});
      vecs.push_back('{4'hC, 4'h7, 4'h3, 8'h15});
      vecs.push_back('{4'hE, 4'hF, 4'h7, 8'h80});
      vecs.push_back('{4'hB, 4'h9, 4'h4, 8'h05});
      vecs.push_back('{4'hA, 4'hF, 4'hF, 8'h1E});

      // Reset values, with a pending request to show req_ready stays low.
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      #2;
      bus.req_valid[0] = 1'b1;
      #1;
      checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
      checkOutput("reset_rsp_data", 32'({bus.rsp_hi, bus.rsp_lo}), 32'd0);
      bus.req_valid[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Table of single operations, alternating requesters.
      for (int i = 0; i < vecs.size(); i++) begin
         gotId = -1; gotRes = -1; gotLat = -1;
         applyStimulus(i % 2, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                       (vecs[i].op == 4'h3) ? 5 : 0);
         checkOutput($sformatf("vec%0d_result", i), 32'(gotRes), 32'(vecs[i].res));
         checkOutput($sformatf("vec%0d_id", i), 32'(gotId), 32'(i % 2));
         checkOutput($sformatf("vec%0d_latency", i), 32'(gotLat), (vecs[i].op == 4'hC) ? 32'd5 : 32'd2);
      end

      // Reset two cycles into a multiply.
      doReset();
      @(posedge clk);
      #1;
      bus.req_valid[1] = 1'b1;
      bus.req_op[7:4]  = 4'hC;
      bus.req_a[7:4]   = 4'hF;
      bus.req_b[7:4]   = 4'hF;
      ok = 1'b0;
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         if (bus.req_ready[1]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeoutFail("midmul_grant");
      @(posedge clk);
      #1;
      bus.req_valid[1] = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("midmul_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("midmul_rsp_data", 32'({bus.rsp_hi, bus.rsp_lo}), 32'd0);
      bus.req_valid[0] = 1'b1;
      #1;
      checkOutput("midmul_req_ready", 32'(bus.req_ready), 32'd0);
      bus.req_valid[0] = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int w = 0; w < 8; w++) begin
         @(negedge clk);
         checkOutput("midmul_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.req_valid = 2'b11;
      bus.req_op    = 8'h33;
      bus.rsp_ready = 1'b1;
      ok = 1'b0;
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         if (bus.req_ready != '0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeoutFail("post_reset_grant");
      checkOutput("post_reset_grant", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.req_valid[0] = 1'b0;
      ok = 1'b0;
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         if (bus.req_ready != '0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeoutFail("post_reset_second_grant");
      checkOutput("post_reset_second_grant", 32'(bus.req_ready), 32'd2);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      repeat (8) @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;

      // Round-robin fairness: both requesters keep four requests queued.
      doReset();
      bus.rsp_ready = 1'b1;
      remaining[0] = 4;
      remaining[1] = 4;
      bus.req_valid = 2'b11;
      bus.req_op    = 8'h44;
      bus.req_a     = 8'($urandom);
      bus.req_b     = 8'($urandom);
      for (int c = 0; c < 100 && order.size() < 8; c++) begin
         @(negedge clk);
         checkOutput("rr_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
         g = -1;
         if (bus.req_ready != '0) begin
            g = bus.req_ready[1] ? 1 : 0;
            order.push_back(g);
         end
         @(posedge clk);
         #1;
         if (g >= 0) begin
            remaining[g]--;
            if (remaining[g] == 0) bus.req_valid[g] = 1'b0;
            else bus.req_a[4*g +: 4] = 4'($urandom);
         end
      end
      if (order.size() < 8) timeoutFail("rr_grants");
      for (int i = 0; i < order.size(); i++) begin
         checkOutput($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
      end
      bus.req_valid = '0;
      repeat (8) @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;

      // Randomized traffic against the behavioural model.
      doReset();
      mLast    = N - 1;
      mBusy    = 1'b0;
      mRespCyc = 0;
      mExpId   = 0;
      mExpRes  = 0;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         expReady = '0;
         g = -1;
         if (!mBusy) begin
            for (int k = 1; k <= N; k++) begin
               j = (mLast + k) % N;
               if (bus.req_valid[j]) begin
                  expReady[j] = 1'b1;
                  g = j;
                  break;
               end
            end
         end
         checkOutput("rnd_req_ready", 32'(bus.req_ready), 32'(expReady));
         expRsp = mBusy && (cyc >= mRespCyc);
         checkOutput("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(expRsp));
         if (expRsp) begin
            checkOutput("rnd_rsp_id", 32'(bus.rsp_id), 32'(mExpId));
            checkOutput("rnd_rsp_data", 32'({bus.rsp_hi, bus.rsp_lo}), 32'(mExpRes));
            if (bus.rsp_ready) mBusy = 1'b0;
         end
         if (g >= 0) begin
            op       = bus.req_op[4*g +: 4];
            mBusy    = 1'b1;
            mExpId   = g;
            mExpRes  = refAlu(int'(op), int'(bus.req_a[4*g +: 4]), int'(bus.req_b[4*g +: 4]));
            mRespCyc = cyc + ((op == 4'hC) ? 5 : 2);
            mLast    = g;
         end
         @(posedge clk);
         #1;
         if (g >= 0) bus.req_valid[g] = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!bus.req_valid[i] && ($urandom_range(0, 2) == 0)) begin
               bus.req_valid[i]     = 1'b1;
               bus.req_op[4*i +: 4] = 4'($urandom);
               bus.req_a[4*i +: 4]  = 4'($urandom);
               bus.req_b[4*i +: 4]  = 4'($urandom);
            end
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;

`ifdef ALU_ARB_STATS_EN
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         checkOutput($sformatf("grant_cnt%0d", i), 32'(grantCnt[16*i +: 16]), 32'(issued[i]));
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
